// File: rtl/fetch_sequencer_pkg.sv
// Constants shared by the fetch sequencer and the instruction decoder:
// one-hot T-state codes, sequencer state encoding and opcode width.
package fetch_pkg;

    localparam int OPCODE_W = 4;

    localparam logic [3:0] T0 = 4'b1000;
    localparam logic [3:0] T1 = 4'b0100;
    localparam logic [3:0] T2 = 4'b0010;
    localparam logic [3:0] T3 = 4'b0001;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/fetch_sequencer_prog_mem.sv
// Program store: 2**ADDR_W opcodes, written on the clock edge, read combinationally.
// Latency: write visible on the cycle after the edge; no backpressure, contents survive reset.
module prog_mem
    import fetch_pkg::*;
#(
    parameter int ADDR_W = 4
) (
    input  logic                clk_i,
    input  logic                we_i,
    input  logic [ADDR_W-1:0]   waddr_i,
    input  logic [OPCODE_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0]   raddr_i,
    output logic [OPCODE_W-1:0] rdata_o
);

    logic [OPCODE_W-1:0] mem_q [2**ADDR_W];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fetch_sequencer.sv
// Drives the decoder's T-state ring and opcode from a writable program store, with run/halt/step control.
// Latency: start at n -> en=T0 at n+1, w valid at n+2; no backpressure, the ring is self-timed.
// STROBE_CHECK_EN adds the sticky seq_err check of the decoder's ir/pc strobes.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int ADDR_W = 4,
    parameter bit WRAP   = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                prog_we,
    input  logic [ADDR_W-1:0]   prog_addr,
    input  logic [OPCODE_W-1:0] prog_data,
    input  logic [ADDR_W:0]     prog_len,
    input  logic                start,
    input  logic                step,
    input  logic                halt_req,
    input  logic                ir_strobe,
    input  logic                pc_strobe,
    output logic [3:0]          en,
    output logic [OPCODE_W-1:0] w,
    output logic [ADDR_W-1:0]   pc_addr,
    output logic                busy,
    output logic                done
`ifdef STROBE_CHECK_EN
    ,
    output logic                seq_err
`endif
);

    state_t              state_q, state_d;
    logic [3:0]          en_q, en_d;
    logic [OPCODE_W-1:0] ir_q, ir_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [ADDR_W-1:0]   last_q, last_d;
    logic                step_q, step_d;
    logic                halt_pend_q, halt_pend_d;
    logic                done_q, done_d;
    logic                start_acc, mem_we, pc_at_last, stop_now;
    logic [OPCODE_W-1:0] mem_rdata;

    prog_mem #(.ADDR_W(ADDR_W)) u_prog_mem (
        .clk_i   (clk),
        .we_i    (mem_we),
        .waddr_i (prog_addr),
        .wdata_i (prog_data),
        .raddr_i (pc_q),
        .rdata_o (mem_rdata)
    );

    // A write in the same cycle as start takes priority; start is dropped.
    assign start_acc  = (state_q == IDLE) && start && !prog_we;
    assign mem_we     = (state_q == IDLE) && prog_we;
    assign pc_at_last = (pc_q == last_q);
    assign stop_now   = halt_pend_q || halt_req || step_q || (!WRAP && pc_at_last);

    always_comb begin
        state_d     = state_q;
        en_d        = en_q;
        ir_d        = ir_q;
        pc_d        = pc_q;
        last_d      = last_q;
        step_d      = step_q;
        halt_pend_d = halt_pend_q;
        done_d      = 1'b0;
        if (start_acc) begin
            state_d     = RUN;
            en_d        = T0;
            pc_d        = '0;
            // A zero length means the whole store.
            last_d      = (prog_len == '0) ? '1 : ADDR_W'(prog_len - 1'b1);
            step_d      = step;
            halt_pend_d = 1'b0;
        end else if (state_q == RUN) begin
            halt_pend_d = halt_pend_q | halt_req;
            case (en_q)
                T0: begin
                    ir_d = mem_rdata;
                    en_d = T1;
                end
                T1: en_d = T2;
                T2: en_d = T3;
                default: begin
                    pc_d = pc_at_last ? '0 : pc_q + 1'b1;
                    en_d = T0;
                    if (stop_now) begin
                        state_d     = IDLE;
                        en_d        = '0;
                        done_d      = 1'b1;
                        step_d      = 1'b0;
                        halt_pend_d = 1'b0;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            en_q        <= '0;
            ir_q        <= '0;
            pc_q        <= '0;
            last_q      <= '0;
            step_q      <= 1'b0;
            halt_pend_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            en_q        <= en_d;
            ir_q        <= ir_d;
            pc_q        <= pc_d;
            last_q      <= last_d;
            step_q      <= step_d;
            halt_pend_q <= halt_pend_d;
            done_q      <= done_d;
        end
    end

    assign en      = en_q;
    assign w       = ir_q;
    assign pc_addr = pc_q;
    assign busy    = (state_q == RUN);
    assign done    = done_q;

`ifdef STROBE_CHECK_EN
    logic first_q, seq_err_q, ir_exp, pc_exp;

    // No pc strobe is owed in the first T0 of a run: no instruction has completed yet.
    assign ir_exp = (en_q == T1);
    assign pc_exp = (en_q == T0) && !first_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            first_q   <= 1'b0;
            seq_err_q <= 1'b0;
        end else begin
            if (start_acc) begin
                first_q <= 1'b1;
            end else if (en_q == T0) begin
                first_q <= 1'b0;
            end
            if ((ir_strobe != ir_exp) || (pc_strobe != pc_exp)) begin
                seq_err_q <= 1'b1;
            end
        end
    end

    assign seq_err = seq_err_q;
`else
    logic unused_strobes;
    assign unused_strobes = ir_strobe ^ pc_strobe;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Runs a WRAP=0 and a WRAP=1 sequencer side by side on shared stimulus and checks both
// against a per-instruction timeline computed from program length, step and halt timing.
module tb_fetch_sequencer;

    localparam int AW = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, prog_we, start, step, halt_req, inj_err;
    logic [AW-1:0] prog_addr;
    logic [3:0]    prog_data;
    logic [AW:0]   prog_len;

    wire [1:0][3:0]    en_o, w_o;
    wire [1:0][AW-1:0] pc_o;
    wire [1:0]         busy_o, done_o, ir_s, pc_s;
    logic [1:0][3:0]   prev_en;
`ifdef STROBE_CHECK_EN
    wire [1:0]         seq_err_o;
`endif

    int total = 0;
    int bad   = 0;
    logic [3:0] tb_mem [16];
    int cur_len, cur_halt;
    int n_run [2];

    typedef struct packed {
        logic [3:0]    en;
        logic [3:0]    w;
        logic [AW-1:0] pc;
        logic          busy;
        logic          done;
        logic          wk;
    } exp_t;

    // Decoder stand-in: ir strobe in T1 (T2 when injecting an error), pc strobe in a T0 that follows a T3.
    always @(posedge clk) prev_en <= en_o;
    for (genvar g = 0; g < 2; g++) begin : g_dec
        assign ir_s[g] = inj_err ? (en_o[g] == 4'b0010) : (en_o[g] == 4'b0100);
        assign pc_s[g] = (en_o[g] == 4'b1000) && (prev_en[g] == 4'b0001);
    end

    fetch_sequencer #(.ADDR_W(AW), .WRAP(1'b0)) u_dut0 (
        .clk(clk), .rst(rst), .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
        .prog_len(prog_len), .start(start), .step(step), .halt_req(halt_req),
        .ir_strobe(ir_s[0]), .pc_strobe(pc_s[0]), .en(en_o[0]), .w(w_o[0]),
        .pc_addr(pc_o[0]), .busy(busy_o[0]), .done(done_o[0])
`ifdef STROBE_CHECK_EN
        , .seq_err(seq_err_o[0])
`endif
    );

    fetch_sequencer #(.ADDR_W(AW), .WRAP(1'b1)) u_dut1 (
        .clk(clk), .rst(rst), .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
        .prog_len(prog_len), .start(start), .step(step), .halt_req(halt_req),
        .ir_strobe(ir_s[1]), .pc_strobe(pc_s[1]), .en(en_o[1]), .w(w_o[1]),
        .pc_addr(pc_o[1]), .busy(busy_o[1]), .done(done_o[1])
`ifdef STROBE_CHECK_EN
        , .seq_err(seq_err_o[1])
`endif
    );

    // Instructions executed per DUT: program end (WRAP=0 only), step, or the instruction holding the halt.
    function automatic void plan_run(input int len, input bit stp, input int h);
        cur_len  = (len == 0) ? 16 : len;
        cur_halt = h;
        for (int d = 0; d < 2; d++) begin
            n_run[d] = (d == 0) ? cur_len : 100000;
            if (stp) n_run[d] = 1;
            if (h > 0 && ((h - 1) / 4 + 1) < n_run[d]) n_run[d] = (h - 1) / 4 + 1;
        end
    endfunction

    function automatic int run_cycles();
        int m;
        m = (n_run[0] > n_run[1]) ? n_run[0] : n_run[1];
        return 4 * m + 2;
    endfunction

    // Cycle c (1 = first cycle after the start edge): instruction k=(c-1)/4 runs at address k mod len.
    function automatic exp_t model(input int d, input int c);
        exp_t e;
        int n, k, ph;
        n  = n_run[d];
        k  = (c - 1) / 4;
        ph = (c - 1) % 4;
        e.wk = 1'b1;
        if (c <= 4 * n) begin
            e.en   = 4'b1000 >> ph;
            e.pc   = AW'(k % cur_len);
            e.busy = 1'b1;
            e.done = 1'b0;
            if (ph > 0)      e.w = tb_mem[k % cur_len];
            else if (k > 0)  e.w = tb_mem[(k - 1) % cur_len];
            else begin       e.w = 4'h0; e.wk = 1'b0; end
        end else begin
            e.en   = 4'b0000;
            e.pc   = AW'(n % cur_len);
            e.busy = 1'b0;
            e.done = (c == 4 * n + 1);
            e.w    = tb_mem[(n - 1) % cur_len];
        end
        return e;
    endfunction

    task automatic write_mem(input int a, input logic [3:0] dat);
        @(negedge clk);
        prog_we   = 1'b1;
        prog_addr = AW'(a);
        prog_data = dat;
        @(negedge clk);
        prog_we   = 1'b0;
        tb_mem[a] = dat;
    endtask

    task automatic launch(input int len, input bit stp, input int h);
        @(negedge clk);
        prog_len = 5'(len);
        step     = stp;
        start    = 1'b1;
        plan_run(len, stp, h);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            total++;
            if ({en_o[d], w_o[d], pc_o[d], busy_o[d], done_o[d]} !== '0) begin
                bad++;
                $display("FAIL reset dut%0d en/w/pc/busy/done got %b/%h/%0d/%b/%b want all zero",
                         d, en_o[d], w_o[d], pc_o[d], busy_o[d], done_o[d]);
            end
`ifdef STROBE_CHECK_EN
            total++;
            if (seq_err_o[d] !== 1'b0) begin
                bad++;
                $display("FAIL reset_seq_err dut%0d got %b want 0", d, seq_err_o[d]);
            end
`endif
        end
        rst = 1'b0;
    endtask

    task automatic test_program();
        exp_t e;
        int ncyc;
        for (int a = 4; a < 16; a++) write_mem(a, 4'($urandom_range(0, 15)));
        write_mem(0, 4'h0); write_mem(1, 4'h1); write_mem(2, 4'h9); write_mem(3, 4'h2);
        launch(4, 1'b0, 14);
        ncyc = run_cycles();
        for (int c = 1; c <= ncyc; c++) begin
            @(negedge clk);
            start = 1'b0; halt_req = (c == cur_halt);
            for (int d = 0; d < 2; d++) begin
                e = model(d, c);
                total++;
                if ({en_o[d], pc_o[d], busy_o[d], done_o[d]} !== {e.en, e.pc, e.busy, e.done}) begin
                    bad++;
                    $display("FAIL program dut%0d c=%0d en/pc/busy/done got %b/%0d/%b/%b want %b/%0d/%b/%b",
                             d, c, en_o[d], pc_o[d], busy_o[d], done_o[d], e.en, e.pc, e.busy, e.done);
                end
                if (e.wk) begin
                    total++;
                    if (w_o[d] !== e.w) begin
                        bad++;
                        $display("FAIL program_w dut%0d c=%0d got %h want %h", d, c, w_o[d], e.w);
                    end
                end
            end
        end
        halt_req = 1'b0;
    endtask

    task automatic test_wrap();
        exp_t e;
        int ncyc;
        launch(3, 1'b0, 30);
        ncyc = run_cycles();
        for (int c = 1; c <= ncyc; c++) begin
            @(negedge clk);
            start = (c == 10); halt_req = (c == cur_halt);
            for (int d = 0; d < 2; d++) begin
                e = model(d, c);
                total++;
                if ({en_o[d], pc_o[d], busy_o[d], done_o[d]} !== {e.en, e.pc, e.busy, e.done}) begin
                    bad++;
                    $display("FAIL wrap dut%0d c=%0d en/pc/busy/done got %b/%0d/%b/%b want %b/%0d/%b/%b",
                             d, c, en_o[d], pc_o[d], busy_o[d], done_o[d], e.en, e.pc, e.busy, e.done);
                end
                if (e.wk) begin
                    total++;
                    if (w_o[d] !== e.w) begin
                        bad++;
                        $display("FAIL wrap_w dut%0d c=%0d got %h want %h", d, c, w_o[d], e.w);
                    end
                end
            end
        end
        start = 1'b0; halt_req = 1'b0;
    endtask

    task automatic test_step();
        exp_t e;
        int ncyc;
        @(negedge clk);
        prog_we = 1'b1; prog_addr = '0; prog_data = 4'h7; prog_len = 5'd4; start = 1'b1; step = 1'b0;
        @(negedge clk);
        prog_we = 1'b0; start = 1'b0; tb_mem[0] = 4'h7;
        for (int d = 0; d < 2; d++) begin
            total++;
            if ({en_o[d], busy_o[d]} !== 5'b0) begin
                bad++;
                $display("FAIL start_with_write dut%0d en/busy got %b/%b want 0000/0", d, en_o[d], busy_o[d]);
            end
        end
        launch(4, 1'b1, 0);
        ncyc = run_cycles();
        for (int c = 1; c <= ncyc; c++) begin
            @(negedge clk);
            start = 1'b0; prog_we = (c == 2); prog_addr = '0; prog_data = 4'hF;
            for (int d = 0; d < 2; d++) begin
                e = model(d, c);
                total++;
                if ({en_o[d], pc_o[d], busy_o[d], done_o[d]} !== {e.en, e.pc, e.busy, e.done}) begin
                    bad++;
                    $display("FAIL step dut%0d c=%0d en/pc/busy/done got %b/%0d/%b/%b want %b/%0d/%b/%b",
                             d, c, en_o[d], pc_o[d], busy_o[d], done_o[d], e.en, e.pc, e.busy, e.done);
                end
                if (e.wk) begin
                    total++;
                    if (w_o[d] !== e.w) begin
                        bad++;
                        $display("FAIL step_w dut%0d c=%0d got %h want %h", d, c, w_o[d], e.w);
                    end
                end
            end
        end
        prog_we = 1'b0; step = 1'b0;
    endtask

    task automatic test_halt();
        exp_t e;
        int ncyc;
        launch(6, 1'b0, 10);
        ncyc = run_cycles();
        for (int c = 1; c <= ncyc; c++) begin
            @(negedge clk);
            start = 1'b0; halt_req = (c == cur_halt);
            for (int d = 0; d < 2; d++) begin
                e = model(d, c);
                total++;
                if ({en_o[d], pc_o[d], busy_o[d], done_o[d]} !== {e.en, e.pc, e.busy, e.done}) begin
                    bad++;
                    $display("FAIL halt dut%0d c=%0d en/pc/busy/done got %b/%0d/%b/%b want %b/%0d/%b/%b",
                             d, c, en_o[d], pc_o[d], busy_o[d], done_o[d], e.en, e.pc, e.busy, e.done);
                end
                if (e.wk) begin
                    total++;
                    if (w_o[d] !== e.w) begin
                        bad++;
                        $display("FAIL halt_w dut%0d c=%0d got %h want %h", d, c, w_o[d], e.w);
                    end
                end
            end
        end
        halt_req = 1'b0;
    endtask

    task automatic test_random();
        exp_t e;
        int ncyc, len, lr, k, h;
        bit stp;
        for (int it = 0; it < 6; it++) begin
            for (int a = 0; a < 16; a++) write_mem(a, 4'($urandom_range(0, 15)));
            len = $urandom_range(0, 16);
            lr  = (len == 0) ? 16 : len;
            stp = ($urandom_range(0, 3) == 0);
            k   = $urandom_range(0, lr + 1);
            h   = 4 * k + 1 + $urandom_range(0, 2);
            launch(len, stp, h);
            ncyc = run_cycles();
            for (int c = 1; c <= ncyc; c++) begin
                @(negedge clk);
                start = 1'b0; halt_req = (c == cur_halt);
                for (int d = 0; d < 2; d++) begin
                    e = model(d, c);
                    total++;
                    if ({en_o[d], pc_o[d], busy_o[d], done_o[d]} !== {e.en, e.pc, e.busy, e.done}) begin
                        bad++;
                        $display("FAIL random it=%0d len=%0d dut%0d c=%0d en/pc/busy/done got %b/%0d/%b/%b want %b/%0d/%b/%b",
                                 it, len, d, c, en_o[d], pc_o[d], busy_o[d], done_o[d], e.en, e.pc, e.busy, e.done);
                    end
                    if (e.wk) begin
                        total++;
                        if (w_o[d] !== e.w) begin
                            bad++;
                            $display("FAIL random_w it=%0d dut%0d c=%0d got %h want %h", it, d, c, w_o[d], e.w);
                        end
                    end
                end
            end
            halt_req = 1'b0; step = 1'b0;
        end
    endtask

    task automatic test_rst_mid();
        launch(4, 1'b0, 0);
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            start = 1'b0;
            rst   = (c == 3);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int d = 0; d < 2; d++) begin
            total++;
            if ({en_o[d], w_o[d], pc_o[d], busy_o[d], done_o[d]} !== '0) begin
                bad++;
                $display("FAIL rst_mid dut%0d en/w/pc/busy/done got %b/%h/%0d/%b/%b want all zero",
                         d, en_o[d], w_o[d], pc_o[d], busy_o[d], done_o[d]);
            end
        end
        launch(4, 1'b1, 0);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            total++;
            if (w_o[d] !== tb_mem[0]) begin
                bad++;
                $display("FAIL rst_mem_kept dut%0d w got %h want %h", d, w_o[d], tb_mem[0]);
            end
        end
        repeat (4) @(negedge clk);
        step = 1'b0;
    endtask

`ifdef STROBE_CHECK_EN
    task automatic test_strobe_check();
        for (int d = 0; d < 2; d++) begin
            total++;
            if (seq_err_o[d] !== 1'b0) begin
                bad++;
                $display("FAIL seq_err_clean dut%0d got %b want 0", d, seq_err_o[d]);
            end
        end
        inj_err = 1'b1;
        launch(4, 1'b1, 0);
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        inj_err = 1'b0;
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            total++;
            if (seq_err_o[d] !== 1'b1) begin
                bad++;
                $display("FAIL seq_err_sticky dut%0d got %b want 1", d, seq_err_o[d]);
            end
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        step = 1'b0;
        for (int d = 0; d < 2; d++) begin
            total++;
            if (seq_err_o[d] !== 1'b0) begin
                bad++;
                $display("FAIL seq_err_rst dut%0d got %b want 0", d, seq_err_o[d]);
            end
        end
    endtask
`endif

    initial begin
        rst = 1'b1; prog_we = 1'b0; start = 1'b0; step = 1'b0; halt_req = 1'b0; inj_err = 1'b0;
        prog_addr = '0; prog_data = '0; prog_len = '0;
        cur_len = 1; cur_halt = 0; n_run[0] = 1; n_run[1] = 1;
        test_reset();
        test_program();
        test_wrap();
        test_step();
        test_halt();
        test_random();
        test_rst_mid();
`ifdef STROBE_CHECK_EN
        test_strobe_check();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
Supplies the instruction decoder with everything it consumes:
- the one-hot T-state ring `en` (T0=1000, T1=0100, T2=0010, T3=0001);
- the current 4-bit opcode `w`, held in an internal instruction register (IR).

Holds a small writable program memory, the program counter (PC) and run/halt/single-step control. The decoder's `ir`/`pc` strobes come back in as `ir_strobe`/`pc_strobe`. They are used only for optional consistency checking; fetch and PC advance are self-timed.

Parameters:
- ADDR_W, 4, program address width; memory depth is 2**ADDR_W words of 4 bits.
- WRAP, 1, 1: PC wraps to 0 after the last instruction and keeps running; 0: stop at end of program.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- prog_we  in  1  program-memory write strobe; honoured only in IDLE.
- prog_addr  in  ADDR_W  write address.
- prog_data  in  4  opcode to write.
- prog_len  in  ADDR_W+1  number of valid instructions (1..2**ADDR_W), sampled on start.
- start  in  1  begin execution from address 0.
- step  in  1  1: execute one instruction and return to IDLE.
- halt_req  in  1  stop after the current instruction completes.
- ir_strobe  in  1  decoder IR-enable feedback.
- pc_strobe  in  1  decoder PC-enable feedback.
- en  out  4  one-hot T-state to decoder.
- w  out  4  IR contents (opcode) to decoder.
- pc_addr  out  ADDR_W  current PC.
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse when execution stops.
- seq_err  out  1  sticky strobe-mismatch flag; present only with the macro.

Behaviour:
- Reset (synchronous): state=IDLE, en=0000, w=0000, pc_addr=0, busy=0, done=0, seq_err=0, step latch=0. Program memory is not cleared.
- States:
  - IDLE: en=0000. Program writes accepted (prog_we writes mem[prog_addr]=prog_data at the clock edge).
  - RUN: ring advances T0→T1→T2→T3→T0, one state per cycle.
  - In RUN, prog_we is ignored.
- start in IDLE (no write that cycle): pc=0, latch prog_len and step, go to RUN with en=1000 next cycle.
  - start and prog_we in the same cycle: the write wins and start is ignored.
  - start while in RUN is ignored.
- Fetch: at the clock edge where en==1000, IR<=mem[pc]. `w` is therefore stable for the whole of T1, T2 and T3, which is when the decoder samples it.
- PC advance: at the edge where en==0001:
  - if pc==prog_len-1: when WRAP=1, pc<=0 and continue; when WRAP=0, go to IDLE, en<=0000, pulse done.
  - otherwise pc<=pc+1, modulo 2**ADDR_W.
- halt_req: sampled every RUN cycle into a pending flag. At the next T3 edge, go to IDLE (pc not advanced past the completed instruction's successor rule: pc still increments), pulse done, clear pending. Any instruction in flight always completes all four T-states.
- step latched: behaves as halt_req pending from T0, so exactly one instruction executes.
- prog_len=0 at start: treated as 2**ADDR_W.
- Reset mid-instruction aborts immediately to the reset values above.
- done and busy are registered. busy falls in the same cycle en returns to 0000.
- Latency: start asserted at cycle n gives en=1000 at n+1, valid w at n+2, first decoder execute strobes at n+4.

Optional Feature:
- Macro STROBE_CHECK_EN.
- Defined: seq_err is implemented. Expected strobes are ir_strobe==1 exactly in cycles where en==0100 and pc_strobe==1 exactly in cycles where en==1000 after a completed instruction; these match the decoder's one-cycle registered lag. Any deviation sets seq_err (sticky until rst).
- Undefined: seq_err port is absent, strobe inputs are unused, no check logic.

Decomposition:
- Package fetch_pkg holds:
  - T-state one-hot constants T0..T3;
  - the state enum {IDLE, RUN};
  - an OPCODE_W=4 constant shared with the decoder.
- One natural sub-module, prog_mem: synchronous-write, asynchronous-read 4-bit RAM, 2**ADDR_W deep.
- Ring counter, PC and control FSM stay in the top level.

Test Plan:
- Load 0,1,9,2 with prog_len=4, WRAP=0, start -> en cycles 1000,0100,0010,0001 ×4; w=0,1,9,2 during the respective T1..T3; done pulses once after the 16th state; pc_addr returns 0.
- WRAP=1, prog_len=3, run 30 cycles -> pc sequence 0,1,2,0,1,2…; w repeats the program; busy stays 1.
- halt_req pulsed during T1 of instruction 2 -> that instruction finishes T3, then en=0000, done=1 for one cycle, busy=0, pc_addr=3.
- step=1 with start -> exactly one T0..T3 sequence, then IDLE; prog_we during RUN with addr=0, data=F -> mem unchanged, w still the original opcode on the next run.
- rst asserted during T2 -> next cycle en=0000, w=0, pc=0, busy=0; program memory contents retained on rerun.
- With STROBE_CHECK_EN, drive ir_strobe high during T2 instead of T1 -> seq_err=1 and stays 1 until rst; correct strobing -> seq_err stays 0.
